// File: rtl/uart_pkg.sv
// Shared constants for the UART host bridge: data width and FSM state encodings.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  localparam logic [1:0] TX_IDLE      = 2'd0;
  localparam logic [1:0] TX_WRITE     = 2'd1;
  localparam logic [1:0] TX_WAIT_BUSY = 2'd2;
  localparam logic [1:0] TX_WAIT_DONE = 2'd3;

  localparam logic [0:0] RX_IDLE     = 1'b0;
  localparam logic [0:0] RX_ACK_WAIT = 1'b1;

endpackage

// File: rtl/uart_host_bridge_if.sv
// Byte-stream and UART-core handshake signals of the host bridge.
// The slave modport is the bridge itself; master is the surrounding host/core logic.
interface uart_host_bridge_if #(
  parameter int FIFO_DEPTH_LOG2 = 4
) ();
  import uart_pkg::*;

  logic [UART_DATA_WIDTH-1:0] tx_data_i;
  logic                       tx_valid_i;
  logic                       tx_ready_o;
  logic [UART_DATA_WIDTH-1:0] rx_data_o;
  logic                       rx_valid_o;
  logic                       rx_ready_i;
  logic [UART_DATA_WIDTH-1:0] uart_data_o;
  logic                       uart_write_o;
  logic                       uart_busy_i;
  logic [UART_DATA_WIDTH-1:0] uart_data_i;
  logic                       uart_ready_i;
  logic                       uart_ack_o;
  logic [FIFO_DEPTH_LOG2:0]   tx_level_o;
  logic [FIFO_DEPTH_LOG2:0]   rx_level_o;

  modport slave (
    input  tx_data_i, tx_valid_i, rx_ready_i, uart_busy_i, uart_data_i, uart_ready_i,
    output tx_ready_o, rx_data_o, rx_valid_o, uart_data_o, uart_write_o, uart_ack_o,
           tx_level_o, rx_level_o
  );

  modport master (
    output tx_data_i, tx_valid_i, rx_ready_i, uart_busy_i, uart_data_i, uart_ready_i,
    input  tx_ready_o, rx_data_o, rx_valid_o, uart_data_o, uart_write_o, uart_ack_o,
           tx_level_o, rx_level_o
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an occupancy level output.
// Pushes into a full FIFO and pops from an empty one are ignored.
module uart_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      pop_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  do_push, do_pop;

  // Full/empty come from the registered level only, so a pop never frees a
  // slot for a push in the same cycle.
  assign full_o  = (level_q == FULL_LEVEL);
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;

endmodule

// File: rtl/uart_host_bridge.sv
// Host-side UART bridge: buffers a byte stream into the core's write/busy transmitter
// port and collects bytes from its ready/ack receiver port into an RX FIFO.
module uart_host_bridge
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input logic               clock_i,
  input logic               reset_i,
  uart_host_bridge_if.slave bus
);
  logic [UART_DATA_WIDTH-1:0] tx_head;
  logic                       tx_full, tx_empty, tx_push, tx_pop;
  logic [FIFO_DEPTH_LOG2:0]   tx_level;
  logic [1:0]                 tx_state_q, tx_state_d;
  logic                       uart_write_q, uart_write_d;
  logic [UART_DATA_WIDTH-1:0] uart_data_q, uart_data_d;

  logic [UART_DATA_WIDTH-1:0] rx_head;
  logic                       rx_full, rx_empty, rx_push, rx_pop;
  logic [FIFO_DEPTH_LOG2:0]   rx_level;
  logic [0:0]                 rx_state_q, rx_state_d;
  logic                       uart_ack_q, uart_ack_d;

  assign tx_push = bus.tx_valid_i && !tx_full;
  assign rx_pop  = bus.rx_ready_i && !rx_empty;

  uart_sync_fifo #(
    .WIDTH      (UART_DATA_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_tx_fifo (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .push_i      (tx_push),
    .push_data_i (bus.tx_data_i),
    .pop_i       (tx_pop),
    .pop_data_o  (tx_head),
    .full_o      (tx_full),
    .empty_o     (tx_empty),
    .level_o     (tx_level)
  );

  uart_sync_fifo #(
    .WIDTH      (UART_DATA_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_rx_fifo (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .push_i      (rx_push),
    .push_data_i (bus.uart_data_i),
    .pop_i       (rx_pop),
    .pop_data_o  (rx_head),
    .full_o      (rx_full),
    .empty_o     (rx_empty),
    .level_o     (rx_level)
  );

  // TX: one write pulse per byte, then follow busy through its full rise/fall
  // so a byte is never offered while the core is still shifting the last one.
  always_comb begin
    tx_state_d   = tx_state_q;
    uart_write_d = 1'b0;
    uart_data_d  = uart_data_q;
    tx_pop       = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty && !bus.uart_busy_i) begin
          uart_write_d = 1'b1;
          uart_data_d  = tx_head;
          tx_pop       = 1'b1;
          tx_state_d   = TX_WRITE;
        end
      end
      TX_WRITE: begin
        tx_state_d = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: begin
        if (bus.uart_busy_i) begin
          tx_state_d = TX_WAIT_DONE;
        end
      end
      TX_WAIT_DONE: begin
        if (!bus.uart_busy_i) begin
          tx_state_d = TX_IDLE;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // RX: capture once per ready assertion; waiting for ready to drop keeps a
  // byte the core is still presenting from being pushed twice.
  always_comb begin
    rx_state_d = rx_state_q;
    uart_ack_d = 1'b0;
    rx_push    = 1'b0;
    if (rx_state_q == RX_IDLE) begin
      if (bus.uart_ready_i && !rx_full) begin
        rx_push    = 1'b1;
        uart_ack_d = 1'b1;
        rx_state_d = RX_ACK_WAIT;
      end
    end else begin
      if (!bus.uart_ready_i) begin
        rx_state_d = RX_IDLE;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      tx_state_q   <= TX_IDLE;
      uart_write_q <= 1'b0;
      uart_data_q  <= '0;
      rx_state_q   <= RX_IDLE;
      uart_ack_q   <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      uart_write_q <= uart_write_d;
      uart_data_q  <= uart_data_d;
      rx_state_q   <= rx_state_d;
      uart_ack_q   <= uart_ack_d;
    end
  end

  assign bus.tx_ready_o   = !tx_full;
  assign bus.tx_level_o   = tx_level;
  assign bus.rx_valid_o   = !rx_empty;
  assign bus.rx_data_o    = rx_head;
  assign bus.rx_level_o   = rx_level;
  assign bus.uart_data_o  = uart_data_q;
  assign bus.uart_write_o = uart_write_q;
  assign bus.uart_ack_o   = uart_ack_q;

endmodule

// File: doc/uart_host_bridge.md
Name: uart_host_bridge

Overview:
- Host-side controller for the UART core; it is the other end of the core's write/busy and ready/ack handshakes.
- Buffers bytes from a valid/ready byte stream into a TX FIFO and drains them into the core's transmitter.
- Pulls received bytes out of the core into an RX FIFO and presents them to the consumer.
- Lets CPU/bus logic move bursts of bytes without tracking UART timing.

Parameters:
- FIFO_DEPTH_LOG2, 4: log2 of each FIFO's depth (4 gives 16 entries per FIFO).

Ports:
- clock_i  in  1  single clock for the whole block.
- reset_i  in  1  synchronous, active-high reset.
- tx_data_i  in  8  byte to transmit.
- tx_valid_i  in  1  tx_data_i is valid; byte is accepted when tx_valid_i && tx_ready_o.
- tx_ready_o  out  1  TX FIFO not full.
- rx_data_o  out  8  oldest received byte (first-word-fall-through).
- rx_valid_o  out  1  RX FIFO not empty.
- rx_ready_i  in  1  consumer pops rx_data_o when rx_valid_o && rx_ready_i.
- uart_data_o  out  8  to the core's data_i.
- uart_write_o  out  1  to the core's write_i.
- uart_busy_i  in  1  from the core's write_busy_o.
- uart_data_i  in  8  from the core's data_o.
- uart_ready_i  in  1  from the core's read_ready_o.
- uart_ack_o  out  1  to the core's ack_i.
- tx_level_o  out  FIFO_DEPTH_LOG2+1  TX FIFO occupancy, 0..2^FIFO_DEPTH_LOG2.
- rx_level_o  out  FIFO_DEPTH_LOG2+1  RX FIFO occupancy.

Behaviour:
- Reset: synchronous. Both FIFOs flushed; both FSMs go to IDLE.
- Reset values: uart_write_o=0, uart_ack_o=0, uart_data_o=0, rx_valid_o=0, levels=0, tx_ready_o=1.
- Reset mid-frame: the bridge drops write/ack on the next edge. It does not abort a frame already inside the core.
- FIFOs: pointers wrap modulo depth; level counter is one bit wider than the pointers. Full means level==depth; empty means level==0.
  - Push when full is ignored; tx_ready_o prevents it on the TX side.
  - Pop when empty is ignored.
  - Simultaneous push+pop on a non-full, non-empty FIFO leaves the level unchanged.
  - Full TX FIFO: tx_ready_o=0 even if a pop occurs the same cycle (no pass-through).
- TX FSM:
  - IDLE: if TX FIFO not empty and uart_busy_i=0, register uart_data_o=head, uart_write_o=1, pop FIFO; go to WRITE.
  - WRITE: uart_write_o=0 (write is a single-cycle pulse, always low afterwards); go to WAIT_BUSY.
  - WAIT_BUSY: wait for uart_busy_i=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for uart_busy_i=0, then go to IDLE.
  - uart_data_o holds its value from the WRITE pulse until the next write.
- TX latency: a byte accepted into an empty TX FIFO at edge N gives uart_write_o=1 in cycle N+2.
- RX FSM:
  - IDLE: if uart_ready_i=1 and RX FIFO not full, push uart_data_i and register uart_ack_o=1 for exactly one cycle; go to ACK_WAIT.
  - IDLE with RX FIFO full: hold, no ack (backpressure). The core keeps its byte.
  - ACK_WAIT: uart_ack_o=0; wait for uart_ready_i=0, then go to IDLE. This prevents double-capture of one byte.
- RX latency: uart_ready_i rising in cycle N (FSM in IDLE, FIFO not full) gives uart_ack_o=1 and rx_valid_o=1 in cycle N+1.
- RX pop and push in the same cycle are both honoured.
- The TX and RX paths are fully independent; simultaneous activity on both is legal.

Decomposition:
- uart_pkg holds:
  - UART_DATA_WIDTH=8;
  - TX state encodings IDLE/WRITE/WAIT_BUSY/WAIT_DONE;
  - RX state encodings IDLE/ACK_WAIT.
- One sub-module, uart_sync_fifo, parameterised on width and depth-log2, first-word-fall-through, with a level output. It is instantiated twice (TX and RX).

Test Plan:
- Single TX byte: push 0xA5 from reset; model raises busy 1 cycle after the write and holds it 100 cycles -> uart_write_o pulses exactly 1 cycle, in cycle N+2, with uart_data_o=0xA5; no second pulse before busy falls.
- TX burst overflow: push 20 bytes 0x00..0x13 back-to-back with the core busy -> tx_ready_o drops after 16 bytes, tx_level_o=16; the core then receives bytes in order 0x00..0x0F, one write per busy cycle.
- RX capture: model raises uart_ready_i with 0x3C and holds it 5 cycles -> exactly one uart_ack_o pulse, rx_valid_o=1, rx_data_o=0x3C, rx_level_o=1; no duplicate push.
- RX backpressure: rx_ready_i=0, deliver 17 bytes -> 16 acked, 17th never acked, rx_level_o=16; pop one -> 17th acked next cycle, order preserved.
- Full-duplex plus simultaneous push/pop: TX and RX traffic concurrently, with RX push and pop in the same cycle -> both streams intact, rx_level_o unchanged on that cycle.
- Reset mid-operation: assert reset_i in WAIT_BUSY with TX level 5 and RX level 3 -> next edge shows all levels 0, write/ack 0, tx_ready_o=1, rx_valid_o=0.
